hub75_column_driver: RTL and testbench

Downstream consumer of the frame manager. Pulses a ready request, captures the pair of 64-pixel scan columns (column N and N+32) on `data_valid`, and drives them onto the HUB75 panel. Each 9-bit pixel is shown with 3-plane binary-coded modulation (BCM). After the last plane it requests the next column pair.

---
 rtl/hub75_column_driver.sv | 166 ++++++++++++++++
 tb/tb_hub75_column_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_column_driver.sv
// HUB75 column driver: requests a column pair, shifts it onto the panel one
// BCM plane at a time, latches it and opens the output-enable window per plane.
module hub75_column_driver #(
   parameter int NUM_ROWS       = 64,
   parameter int SCAN_RATE      = 32,
   parameter int RGB_RES        = 9,
   parameter int BASE_ON_CYCLES = 8
) (
   input  logic                                  clk_in,
   input  logic                                  rst_in,
   input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] columns,
   input  logic [$clog2(SCAN_RATE)-1:0]          col_num1,
   input  logic                                  data_valid,
   output logic                                  hub75_ready,
   output logic [2:0]                            rgb0,
   output logic [2:0]                            rgb1,
   output logic [$clog2(SCAN_RATE)-1:0]          addr,
   output logic                                  clk_out,
   output logic                                  latch,
   output logic                                  oe_n
);

   localparam int AW = $clog2(SCAN_RATE);
   localparam int PW = $clog2(NUM_ROWS);
   localparam int DW = $clog2((BASE_ON_CYCLES << 2) + 1);
   localparam int CB = RGB_RES / 3;
   localparam logic [PW-1:0] LAST_PIX = PW'(NUM_ROWS - 1);

   typedef enum logic [2:0] {REQ, WAIT, SHIFT, BLANK, LATCH, DISPLAY} state_t;

   state_t                             state, state_d;
   logic [1:0]                         plane, plane_d, plane_p1;
   logic [PW-1:0]                      pix, pix_d, pix_m1;
   logic                               phase, phase_d;
   logic [DW-1:0]                      dcnt, dcnt_d;
   logic [NUM_ROWS-1:0][RGB_RES-1:0]   cap0, cap1;
   logic [AW-1:0]                      row_addr;
   logic                               capture;
   logic                               ready_d, clk_d, latch_d, oe_d;
   logic [2:0]                         rgb0_d, rgb1_d;
   logic [AW-1:0]                      addr_d;

   function automatic logic [2:0] plane_bits(input logic [RGB_RES-1:0] px,
                                             input logic [1:0] p);
      return {px[2*CB + int'(p)], px[CB + int'(p)], px[int'(p)]};
   endfunction

   assign pix_m1   = pix - PW'(1);
   assign plane_p1 = plane + 2'd1;

   // State reflects what the outputs show this cycle; outputs are registered
   // from the next-state decode so the panel pins never see combinational glitches.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state       <= REQ;
         plane       <= '0;
         pix         <= '0;
         phase       <= 1'b0;
         dcnt        <= '0;
         cap0        <= '0;
         cap1        <= '0;
         row_addr    <= '0;
         hub75_ready <= 1'b0;
         rgb0        <= '0;
         rgb1        <= '0;
         addr        <= '0;
         clk_out     <= 1'b0;
         latch       <= 1'b0;
         oe_n        <= 1'b1;
      end else begin
         state       <= state_d;
         plane       <= plane_d;
         pix         <= pix_d;
         phase       <= phase_d;
         dcnt        <= dcnt_d;
         hub75_ready <= ready_d;
         rgb0        <= rgb0_d;
         rgb1        <= rgb1_d;
         addr        <= addr_d;
         clk_out     <= clk_d;
         latch       <= latch_d;
         oe_n        <= oe_d;
         if (capture) begin
            cap0     <= columns[0];
            cap1     <= columns[1];
            row_addr <= col_num1;
         end
      end
   end

   // REQ stays put until the ready pulse has actually been driven, which also
   // gives the pulse right after reset release.
   always_comb begin
      state_d = state;
      plane_d = plane;
      pix_d   = pix;
      phase_d = phase;
      dcnt_d  = dcnt;
      capture = 1'b0;
      ready_d = 1'b0;
      rgb0_d  = rgb0;
      rgb1_d  = rgb1;
      clk_d   = 1'b0;
      latch_d = 1'b0;
      oe_d    = 1'b1;
      addr_d  = addr;
      case (state)
         REQ: begin
            if (!hub75_ready) ready_d = 1'b1;
            else              state_d = WAIT;
         end
         WAIT: begin
            if (data_valid) begin
               capture = 1'b1;
               state_d = SHIFT;
               plane_d = 2'd0;
               pix_d   = LAST_PIX;
               phase_d = 1'b0;
               rgb0_d  = plane_bits(columns[0][LAST_PIX], 2'd0);
               rgb1_d  = plane_bits(columns[1][LAST_PIX], 2'd0);
            end
         end
         SHIFT: begin
            if (!phase) begin
               phase_d = 1'b1;
               clk_d   = 1'b1;
            end else if (pix == '0) begin
               state_d = BLANK;
            end else begin
               pix_d   = pix_m1;
               phase_d = 1'b0;
               rgb0_d  = plane_bits(cap0[pix_m1], plane);
               rgb1_d  = plane_bits(cap1[pix_m1], plane);
            end
         end
         BLANK: begin
            state_d = LATCH;
            latch_d = 1'b1;
            addr_d  = row_addr;
         end
         LATCH: begin
            state_d = DISPLAY;
            oe_d    = 1'b0;
            dcnt_d  = DW'((BASE_ON_CYCLES << plane) - 1);
         end
         DISPLAY: begin
            if (dcnt != '0) begin
               dcnt_d = dcnt - DW'(1);
               oe_d   = 1'b0;
            end else if (plane == 2'd2) begin
               state_d = REQ;
               ready_d = 1'b1;
            end else begin
               state_d = SHIFT;
               plane_d = plane_p1;
               pix_d   = LAST_PIX;
               phase_d = 1'b0;
               rgb0_d  = plane_bits(cap0[LAST_PIX], plane_p1);
               rgb1_d  = plane_bits(cap1[LAST_PIX], plane_p1);
            end
         end
         default: state_d = REQ;
      endcase
   end

endmodule

// File: tb/tb_hub75_column_driver.sv
// Bench for hub75_column_driver: an upstream driver issues column pairs and
// queues expected panel activity; a monitor compares what the panel pins do.
module tb_hub75_column_driver;

   localparam int NUM_ROWS  = 64;
   localparam int SCAN_RATE = 32;
   localparam int RGB_RES   = 9;
   localparam int BASE_ON   = 8;
   localparam int AW        = $clog2(SCAN_RATE);
   localparam int COL_CYCLES = 3 * (2 * NUM_ROWS + 2) + BASE_ON * (1 + 2 + 4);

   typedef logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0] cols_t;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b0;
   cols_t         columns = '0;
   logic [AW-1:0] col_num1 = '0;
   logic          data_valid = 1'b0;
   logic          hub75_ready;
   logic [2:0]    rgb0, rgb1;
   logic [AW-1:0] addr;
   logic          clk_out, latch, oe_n;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [5:0] shift_q[$];
   int         addr_q[$];
   int         oe_q[$];
   int         ready_q[$];

   hub75_column_driver #(
      .NUM_ROWS(NUM_ROWS), .SCAN_RATE(SCAN_RATE), .RGB_RES(RGB_RES), .BASE_ON_CYCLES(BASE_ON)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .columns(columns), .col_num1(col_num1),
      .data_valid(data_valid), .hub75_ready(hub75_ready), .rgb0(rgb0), .rgb1(rgb1),
      .addr(addr), .clk_out(clk_out), .latch(latch), .oe_n(oe_n)
   );

   initial forever #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   // Each channel of a pixel is an unsigned 3-bit intensity; plane p shows bit p of it.
   function automatic logic [2:0] ref_bits(input int px, input int p);
      int w, r, g, b;
      w = 1 << p;
      r = (px / 64) % 8;
      g = (px / 8) % 8;
      b = px % 8;
      return 3'(((r / w) % 2) * 4 + ((g / w) % 2) * 2 + (b / w) % 2);
   endfunction

   function automatic cols_t random_cols();
      cols_t c;
      for (int h = 0; h < 2; h++)
         for (int i = 0; i < NUM_ROWS; i++)
            c[h][i] = RGB_RES'($urandom_range(0, (1 << RGB_RES) - 1));
      return c;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_output({tag, "_ready"}, int'(hub75_ready), 0);
      check_output({tag, "_rgb0"}, int'(rgb0), 0);
      check_output({tag, "_rgb1"}, int'(rgb1), 0);
      check_output({tag, "_addr"}, int'(addr), 0);
      check_output({tag, "_clk_out"}, int'(clk_out), 0);
      check_output({tag, "_latch"}, int'(latch), 0);
      check_output({tag, "_oe_n"}, int'(oe_n), 1);
   endtask

   // Offers one column pair; optionally follows it with a stray strobe while busy.
   task automatic apply_stimulus(input cols_t cols, input logic [AW-1:0] col,
                                 input bit wait_ready, input int delay, input int spur_at);
      bit seen;
      seen = 1'b0;
      if (wait_ready) begin
         for (int n = 0; n < 2000 && !seen; n++) begin
            @(negedge clk_in);
            if (hub75_ready) seen = 1'b1;
         end
         if (!seen) begin
            check_output("ready_timeout", 0, 1);
            return;
         end
         repeat (1 + delay) begin @(posedge clk_in); #2; end
      end else begin
         @(posedge clk_in); #2;
      end
      columns    = cols;
      col_num1   = col;
      data_valid = 1'b1;
      for (int p = 0; p < 3; p++) begin
         for (int i = NUM_ROWS - 1; i >= 0; i--)
            shift_q.push_back({ref_bits(int'(cols[0][i]), p), ref_bits(int'(cols[1][i]), p)});
         addr_q.push_back(int'(col));
         oe_q.push_back(BASE_ON * (1 << p));
      end
      ready_q.push_back(cyc + 1 + COL_CYCLES);
      @(posedge clk_in); #2;
      data_valid = 1'b0;
      if (spur_at > 0) begin
         repeat (spur_at - 1) begin @(posedge clk_in); #2; end
         columns    = random_cols();
         col_num1   = col ^ AW'(5'h1f);
         data_valid = 1'b1;
         @(posedge clk_in); #2;
         data_valid = 1'b0;
      end
   endtask

   // Monitor: pops expectations whenever the panel shows a shift edge, latch,
   // end of an OE window or a ready pulse.
   initial begin
      logic       prev_clk, prev_latch, prev_oe, prev_ready;
      logic [AW-1:0] prev_addr;
      int         rise_cnt, oe_run;
      prev_clk = 0; prev_latch = 0; prev_oe = 1; prev_ready = 0; prev_addr = '0;
      rise_cnt = 0; oe_run = 0;
      forever begin
         @(negedge clk_in);
         if (!rst_in) begin
            prev_clk = 0; prev_latch = 0; prev_oe = 1; prev_ready = 0;
            prev_addr = addr; rise_cnt = 0; oe_run = 0;
         end else begin
            if (hub75_ready) begin
               if (prev_ready) check_output("ready_width", 2, 1);
               else if (ready_q.size() == 0) check_output("ready_unexpected_cycle", cyc, -1);
               else check_output("ready_cycle", cyc, ready_q.pop_front());
            end
            if (clk_out && !prev_clk) begin
               rise_cnt++;
               check_output("shift_oe_n", int'(oe_n), 1);
               if (shift_q.size() == 0) check_output("shift_unexpected", int'({rgb0, rgb1}), -1);
               else check_output("shift_rgb", int'({rgb0, rgb1}), int'(shift_q.pop_front()));
            end
            if (latch) begin
               check_output("rises_per_plane", rise_cnt, NUM_ROWS);
               rise_cnt = 0;
               if (addr_q.size() == 0) check_output("latch_unexpected", int'(addr), -1);
               else check_output("latch_addr", int'(addr), addr_q.pop_front());
            end
            if (addr != prev_addr && !latch)
               check_output("addr_change_without_latch", int'(addr), int'(prev_addr));
            if (!oe_n) begin
               if (prev_oe) check_output("latch_before_oe", int'(prev_latch), 1);
               oe_run++;
            end else if (!prev_oe) begin
               if (oe_q.size() == 0) check_output("oe_unexpected", oe_run, -1);
               else check_output("oe_run_len", oe_run, oe_q.pop_front());
               oe_run = 0;
            end
            prev_clk = clk_out; prev_latch = latch; prev_oe = oe_n;
            prev_ready = hub75_ready; prev_addr = addr;
         end
      end
   end

   initial begin
      cols_t c;
      int    n_ready, n_latch;
      bit    drained;

      // Held in reset: panel dark, everything else low.
      repeat (3) @(negedge clk_in);
      check_reset_outputs("reset_hold");

      // Release: one ready pulse, then silence while nobody answers.
      @(posedge clk_in); #2;
      rst_in = 1'b1;
      ready_q.push_back(cyc + 1);
      n_ready = 0;
      repeat (1000) begin
         @(negedge clk_in);
         if (hub75_ready) n_ready++;
      end
      check_output("ready_pulses_idle", n_ready, 1);
      check_output("ready_consumed", ready_q.size(), 0);

      // Directed pixel mapping, row address 5, with a stray strobe mid-shift.
      c = '0;
      c[0][NUM_ROWS-1] = 9'b101_010_111;
      apply_stimulus(c, AW'(5), 1'b0, 0, 30);
      n_latch = 0;
      for (int n = 0; n < 500 && n_latch == 0; n++) begin
         @(negedge clk_in);
         if (latch) n_latch++;
      end
      check_output("first_latch_seen", n_latch, 1);
      @(negedge clk_in);
      check_output("addr_after_latch", int'(addr), 5);

      // Randomized column pairs with random response delay and stray strobes.
      for (int k = 0; k < 4; k++)
         apply_stimulus(random_cols(), AW'($urandom_range(0, SCAN_RATE - 1)), 1'b1,
                        int'($urandom_range(0, 3)), int'($urandom_range(10, 400)));

      // Reset during the plane-1 display window.
      apply_stimulus(random_cols(), AW'(17), 1'b1, 0, 0);
      n_latch = 0;
      for (int n = 0; n < 1000 && n_latch < 2; n++) begin
         @(negedge clk_in);
         if (latch) n_latch++;
      end
      check_output("plane1_latch_seen", n_latch, 2);
      repeat (3) @(negedge clk_in);
      check_output("plane1_display_oe_n", int'(oe_n), 0);
      @(posedge clk_in); #2;
      rst_in = 1'b0;
      #1;
      check_output("async_reset_oe_n", int'(oe_n), 1);
      shift_q.delete(); addr_q.delete(); oe_q.delete(); ready_q.delete();
      repeat (2) @(negedge clk_in);
      check_reset_outputs("reset_mid");
      @(posedge clk_in); #2;
      rst_in = 1'b1;
      ready_q.push_back(cyc + 1);
      apply_stimulus(random_cols(), AW'(22), 1'b1, 1, 0);
      check_output("addr_after_restart", int'(addr), 0);
      repeat (60) @(negedge clk_in);
      check_output("addr_before_latch", int'(addr), 0);

      // Let the monitor consume every outstanding expectation.
      drained = 1'b0;
      for (int n = 0; n < 3000 && !drained; n++) begin
         @(negedge clk_in);
         if (shift_q.size() + addr_q.size() + oe_q.size() + ready_q.size() == 0) drained = 1'b1;
      end
      check_output("queues_drained", shift_q.size() + addr_q.size() + oe_q.size() + ready_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
